// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one byte-enabled sync-read RAM between IF and LS ports, LS priority with IF starvation guard
// Optional misaligned-LS trap enabled by defining ARB_MISALIGN_TRAP_EN
module mem_port_arbiter #(
  parameter int ADDR_W = 9,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              ls_req,
  input  logic [31:0]       ls_addr,
  input  logic              ls_wren,
  input  logic [3:0]        ls_byteen,
  input  logic [31:0]       ls_wdata,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [31:0]       ls_rdata,
  output logic              ls_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_byteen,
  output logic              mem_wren,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);
  typedef enum logic [1:0] {O_NONE, O_IF, O_LS} owner_t;
  owner_t owner, owner_nx;
  logic [3:0] starve_cnt, starve_nx;
  logic mis;
  logic unused_bits;
  assign unused_bits = ^{if_addr[31:ADDR_W+2], if_addr[1:0], ls_addr[31:ADDR_W+2], ls_addr[1:0]};
`ifdef ARB_MISALIGN_TRAP_EN
  logic err_q;
  assign mis = (ls_byteen == 4'b0011 && ls_addr[0]) || (ls_byteen == 4'b1111 && ls_addr[1:0] != 2'b00);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) err_q <= 1'b0;
    else err_q <= ls_gnt && mis;
  assign ls_err = err_q;
`else
  assign mis = 1'b0;
  assign ls_err = 1'b0;
`endif
  assign if_gnt = if_req && (!ls_req || starve_cnt == 4'(STARVE_MAX));
  assign ls_gnt = ls_req && !if_gnt;
  assign if_rvalid = owner == O_IF;
  assign ls_rvalid = owner == O_LS;
  assign if_rdata = mem_rdata;
  assign ls_rdata = mem_rdata;
  assign mem_wdata = ls_wdata;
  always_comb begin
    mem_addr = if_gnt ? if_addr[ADDR_W+1:2] : ls_addr[ADDR_W+1:2];
    mem_byteen = if_gnt ? 4'b1111 : (ls_gnt && !mis) ? ls_byteen : 4'b0000;
    mem_wren = ls_gnt && ls_wren && !mis;
    starve_nx = (if_req && !if_gnt) ? ((starve_cnt == 4'(STARVE_MAX)) ? starve_cnt : starve_cnt + 4'd1) : 4'd0;
    owner_nx = if_gnt ? O_IF : (ls_gnt && !ls_wren) ? O_LS : O_NONE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      owner <= O_NONE;
      starve_cnt <= 4'd0;
    end else begin
      owner <= owner_nx;
      starve_cnt <= starve_nx;
    end
endmodule
